// File: rtl/display_sequencer.sv
// Frame buffer plus timed readout: collects depth_p words, then presents each for
// dwell_cycles_p clocks (or until step_i). Optional replay via DISPLAY_SEQUENCER_REPLAY_EN.
module display_sequencer #(
  parameter int width_p        = 8,
  parameter int depth_p        = 4,
  parameter int dwell_cycles_p = 60000000
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       valid_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  input  logic                       flush_i,
  input  logic                       step_i,
`ifdef DISPLAY_SEQUENCER_REPLAY_EN
  input  logic                       replay_i,
`endif
  output logic [width_p-1:0]         data_o,
  output logic [$clog2(depth_p)-1:0] index_o,
  output logic                       displaying_o,
  output logic                       word_done_o
);

  localparam int IdxW = $clog2(depth_p);
  localparam int CntW = $clog2(depth_p + 1);
  localparam int DwW  = (dwell_cycles_p > 1) ? $clog2(dwell_cycles_p) : 1;
  localparam logic [CntW-1:0] DepthC   = CntW'(depth_p);
  localparam logic [DwW-1:0]  DwellEnd = DwW'(dwell_cycles_p - 1);

  typedef enum logic {LOAD, DISPLAY} state_e;

  state_e                            state_q, state_d;
  logic [CntW-1:0]                   count_q, len_q, disp_len, count_inc;
  logic [IdxW-1:0]                   wr_ptr_q, rd_idx_q;
  logic [DwW-1:0]                    dwell_q;
  logic [depth_p-1:0][width_p-1:0]   mem_q;
  logic                              armed_q;
  logic                              wr_fire, go_disp, advance, last_rd;
`ifdef DISPLAY_SEQUENCER_REPLAY_EN
  logic                              len_valid_q;
`endif

  // armed_q holds ready_o low until the first clock after reset release
  assign ready_o   = (state_q == LOAD) && armed_q && (count_q < DepthC);
  assign wr_fire   = ready_o && valid_i;
  assign count_inc = count_q + CntW'(1);
  assign last_rd   = (CntW'(rd_idx_q) == len_q - CntW'(1));

  always_comb begin
    state_d     = state_q;
    go_disp     = 1'b0;
    disp_len    = len_q;
    advance     = 1'b0;
    word_done_o = 1'b0;
    case (state_q)
      LOAD: begin
        if (wr_fire) begin
          if (count_inc == DepthC || flush_i) begin
            go_disp  = 1'b1;
            disp_len = count_inc;
          end
        end else if (flush_i && count_q != '0) begin
          go_disp  = 1'b1;
          disp_len = count_q;
        end
`ifdef DISPLAY_SEQUENCER_REPLAY_EN
        else if (replay_i && count_q == '0 && len_valid_q) begin
          go_disp  = 1'b1;
          disp_len = len_q;
        end
`endif
        if (go_disp) state_d = DISPLAY;
      end
      DISPLAY: begin
        advance     = (dwell_q == DwellEnd) || step_i;
        word_done_o = advance;
        if (advance && last_rd) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= LOAD;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_idx_q <= '0;
      dwell_q  <= '0;
      len_q    <= '0;
      armed_q  <= 1'b0;
`ifdef DISPLAY_SEQUENCER_REPLAY_EN
      len_valid_q <= 1'b0;
`endif
    end else begin
      armed_q <= 1'b1;
      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + IdxW'(1);
        count_q  <= count_inc;
`ifdef DISPLAY_SEQUENCER_REPLAY_EN
        len_valid_q <= 1'b0;
`endif
      end
      // entry overrides the write-pointer bump so it never wraps on a full frame
      if (go_disp) begin
        rd_idx_q <= '0;
        dwell_q  <= '0;
        len_q    <= disp_len;
        wr_ptr_q <= '0;
`ifdef DISPLAY_SEQUENCER_REPLAY_EN
        len_valid_q <= 1'b1;
`endif
      end
      if (state_q == DISPLAY) begin
        if (advance) begin
          dwell_q <= '0;
          if (last_rd) begin
            rd_idx_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
          end else begin
            rd_idx_q <= rd_idx_q + IdxW'(1);
          end
        end else begin
          dwell_q <= dwell_q + DwW'(1);
        end
      end
    end
  end

  // plain flops, no reset: contents survive a frame for replay
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= data_i;
  end

  assign displaying_o = (state_q == DISPLAY);
  assign index_o      = displaying_o ? rd_idx_q : wr_ptr_q;
  assign data_o       = displaying_o ? mem_q[rd_idx_q] :
                        (wr_ptr_q == '0) ? '0 : mem_q[wr_ptr_q - IdxW'(1)];

endmodule
